cardinal_issue_ctrl: RTL and testbench

- Issue/stall controller for the 4-stage Cardinal pipeline (IF, ID, EX/MEM, WB). It sits beside the ID stage.
- It decides each cycle whether the decoded instruction in IF/ID may issue into EX/MEM.
- It sequences multi-cycle ALU ops with a busy counter, detects RAW hazards against in-flight destinations, and produces the pipeline `stall`, branch `flush` and EX completion strobes.
- The processor core consumes `stall`/`flush` to gate the PC and the IF/ID register.

---
 rtl/cardinal_pkg.sv | 43 ++++
 rtl/cardinal_issue_ctrl_if.sv | 21 ++
 rtl/cardinal_scoreboard.sv | 38 +++
 rtl/cardinal_issue_ctrl.sv | 60 ++++++
 tb/tb_cardinal_issue_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cardinal_pkg.sv
// cardinal_pkg: opcodes, ALU function codes, latency-class and operand decode for the Cardinal issue controller
package cardinal_pkg;
  localparam logic [0:5] VALU  = 6'b101010;
  localparam logic [0:5] VLD   = 6'b100000;
  localparam logic [0:5] VSD   = 6'b100001;
  localparam logic [0:5] VBEZ  = 6'b100010;
  localparam logic [0:5] VBNEZ = 6'b100011;
  localparam logic [0:5] VNOP  = 6'b111100;
  localparam logic [0:5] VAND   = 6'd1;
  localparam logic [0:5] VOR    = 6'd2;
  localparam logic [0:5] VXOR   = 6'd3;
  localparam logic [0:5] VNOT   = 6'd4;
  localparam logic [0:5] VMOV   = 6'd5;
  localparam logic [0:5] VADD   = 6'd6;
  localparam logic [0:5] VSUB   = 6'd7;
  localparam logic [0:5] VMULEU = 6'd8;
  localparam logic [0:5] VMULOU = 6'd9;
  localparam logic [0:5] VSLL   = 6'd10;
  localparam logic [0:5] VSRL   = 6'd11;
  localparam logic [0:5] VSRA   = 6'd12;
  localparam logic [0:5] VDIV   = 6'd13;
  localparam logic [0:5] VMOD   = 6'd14;
  localparam logic [0:5] VSQEU  = 6'd15;
  localparam logic [0:5] VSQOU  = 6'd16;
  localparam logic [0:5] VSQRT  = 6'd17;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {LC_ONE, LC_SHORT, LC_MID, LC_LONG} lat_t;
  typedef struct packed {logic dst; logic ra; logic rb; logic rd;} use_t;
  typedef struct packed {logic v; logic [0:4] r;} tag_t;
  // Writes to r0 are discarded, so such ALU ops retire in a single cycle.
  function automatic lat_t lat_class(input logic [0:5] op, input logic [0:5] fn, input logic [0:4] rd);
    return (op != VALU || rd == '0) ? LC_ONE :
           (fn inside {VDIV, VSQRT}) ? LC_LONG :
           (fn inside {VMULEU, VMULOU, VMOD, VSQEU, VSQOU}) ? LC_MID :
           (fn inside {VADD, VSUB, VSLL, VSRL, VSRA}) ? LC_SHORT : LC_ONE;
  endfunction
  function automatic use_t decode(input logic [0:5] op, input logic [0:5] fn, input logic [0:4] rd);
    return '{dst: (op == VALU || op == VLD) && rd != '0,
             ra: op == VALU,
             rb: op == VALU && !(fn inside {VNOT, VMOV}),
             rd: op inside {VSD, VBEZ, VBNEZ}};
  endfunction
endpackage

// File: rtl/cardinal_issue_ctrl_if.sv
// cardinal_issue_ctrl_if: ID-stage fields into the issue controller and pipeline control back to the core
// master = core side (drives id_* and branch_cond), slave = controller (drives stall/flush/issue/alu_busy/ex_done/busy_cnt)
interface cardinal_issue_ctrl_if #(parameter int CNT_W = 3);
  logic id_valid;
  logic [0:5] id_opcode;
  logic [0:5] id_alu_opcode;
  logic [0:4] id_rD;
  logic [0:4] id_rA;
  logic [0:4] id_rB;
  logic branch_cond;
  logic stall;
  logic flush;
  logic issue;
  logic alu_busy;
  logic ex_done;
  logic [0:CNT_W-1] busy_cnt;
  modport master (output id_valid, id_opcode, id_alu_opcode, id_rD, id_rA, id_rB, branch_cond,
                  input stall, flush, issue, alu_busy, ex_done, busy_cnt);
  modport slave (input id_valid, id_opcode, id_alu_opcode, id_rD, id_rA, id_rB, branch_cond,
                 output stall, flush, issue, alu_busy, ex_done, busy_cnt);
endinterface

// File: rtl/cardinal_scoreboard.sv
// cardinal_scoreboard: EX/WB destination tags and RAW hazard compare for the ID instruction
// Ports: clk, reset, id_valid, issue, ex_done, uses (decoded operand mask), rd/ra/rb, hazard out.
// CARDINAL_RF_WRITE_THROUGH_EN drops the WB tag from the compare.
module cardinal_scoreboard import cardinal_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic id_valid,
  input  logic issue,
  input  logic ex_done,
  input  use_t uses,
  input  logic [0:4] rd,
  input  logic [0:4] ra,
  input  logic [0:4] rb,
  output logic hazard
);
`ifdef CARDINAL_RF_WRITE_THROUGH_EN
  localparam logic WB_CHK = 1'b0;
`else
  localparam logic WB_CHK = 1'b1;
`endif
  tag_t ex_tag, wb_tag;
  function automatic logic seen(input tag_t ex, input tag_t wb, input logic [0:4] r);
    return (ex.v && ex.r == r) || (WB_CHK && wb.v && wb.r == r);
  endfunction
  // A same-cycle issue replaces the retiring EX tag; the WB tag lives for one cycle only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_tag <= '0;
      wb_tag <= '0;
    end else begin
      ex_tag <= issue ? '{uses.dst, rd} : ex_done ? '0 : ex_tag;
      wb_tag <= ex_done ? ex_tag : '0;
    end
  end
  assign hazard = id_valid && ((uses.ra && seen(ex_tag, wb_tag, ra)) ||
                               (uses.rb && seen(ex_tag, wb_tag, rb)) ||
                               (uses.rd && seen(ex_tag, wb_tag, rd)));
endmodule

// File: rtl/cardinal_issue_ctrl.sv
// cardinal_issue_ctrl: issue/stall/flush control beside the ID stage of the 4-stage Cardinal pipeline
// Ports: clk, reset (sync, active high), bus (cardinal_issue_ctrl_if.slave).
// Optional macro CARDINAL_RF_WRITE_THROUGH_EN: register-file write-through, WB tag no longer hazards.
module cardinal_issue_ctrl import cardinal_pkg::*; #(
  parameter int LAT_LONG  = 5,
  parameter int LAT_MID   = 4,
  parameter int LAT_SHORT = 3,
  parameter int CNT_W     = 3
) (
  input logic clk,
  input logic reset,
  cardinal_issue_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [0:CNT_W-1] cnt, cnt_nx, lat_m1;
  logic done_q, done_nx, hazard;
  use_t uses;
  lat_t lc;
  assign uses = decode(bus.id_opcode, bus.id_alu_opcode, bus.id_rD);
  assign lc = lat_class(bus.id_opcode, bus.id_alu_opcode, bus.id_rD);
  assign lat_m1 = lc == LC_LONG  ? CNT_W'(LAT_LONG - 1) :
                  lc == LC_MID   ? CNT_W'(LAT_MID - 1) :
                  lc == LC_SHORT ? CNT_W'(LAT_SHORT - 1) : '0;
  assign bus.busy_cnt = cnt;
  cardinal_scoreboard sb (
    .clk(clk), .reset(reset), .id_valid(bus.id_valid), .issue(bus.issue), .ex_done(bus.ex_done),
    .uses(uses), .rd(bus.id_rD), .ra(bus.id_rA), .rb(bus.id_rB), .hazard(hazard)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end
  // done_q marks a single-cycle op that retires from EX/MEM in the cycle after its issue.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    done_nx      = 1'b0;
    bus.alu_busy = state == BUSY;
    bus.stall    = state == BUSY || hazard;
    bus.issue    = state == IDLE && bus.id_valid && !hazard && bus.id_opcode != VNOP;
    bus.flush    = state == IDLE && bus.id_valid && !hazard && bus.branch_cond &&
                   (bus.id_opcode inside {VBEZ, VBNEZ});
    bus.ex_done  = state == BUSY ? cnt == CNT_W'(1) : done_q;
    if (state == BUSY) begin
      cnt_nx   = cnt - CNT_W'(1);
      state_nx = cnt == CNT_W'(1) ? IDLE : BUSY;
    end else if (bus.issue) begin
      cnt_nx   = lat_m1;
      state_nx = lat_m1 != '0 ? BUSY : IDLE;
      done_nx  = lat_m1 == '0;
    end
  end
endmodule

// File: tb/tb_cardinal_issue_ctrl.sv
// tb_cardinal_issue_ctrl: directed vector table, hand sequences and randomized reference-model check
module tb_cardinal_issue_ctrl;
  import cardinal_pkg::*;
`ifdef CARDINAL_RF_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  typedef struct {
    bit rst;
    bit v;
    logic [0:5] op;
    logic [0:5] fn;
    logic [0:4] rd;
    logic [0:4] ra;
    logic [0:4] rb;
    bit cond;
    logic [7:0] x;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cardinal_issue_ctrl_if #(.CNT_W(3)) bus ();
  cardinal_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] got;
  assign got = {bus.stall, bus.flush, bus.issue, bus.alu_busy, bus.ex_done, bus.busy_cnt};

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[$];
  logic [0:5] fns [18];
  int ready [32];
  bit done_at [0:4095];

  function automatic logic [7:0] e(input bit s, f, i, b, d, input int n);
    return {s, f, i, b, d, 3'(n)};
  endfunction

  function automatic vec_t mk(input bit r, v, input logic [0:5] op, fn, input logic [0:4] rd, ra, rb,
                              input bit cond, input logic [7:0] x);
    vec_t t;
    t.rst = r; t.v = v; t.op = op; t.fn = fn; t.rd = rd; t.ra = ra; t.rb = rb; t.cond = cond; t.x = x;
    return t;
  endfunction

  function automatic int lat_of(input logic [0:5] op, fn, input logic [0:4] rd);
    if (op != VALU || rd == 0) return 1;
    case (fn)
      VDIV, VSQRT: return 5;
      VMULEU, VMULOU, VMOD, VSQEU, VSQOU: return 4;
      VADD, VSUB, VSLL, VSRL, VSRA: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit reads(input logic [0:5] op, fn, input logic [0:4] rd, ra, rb, input int r);
    if (r == 0) return 1'b0;
    if (op == VALU) return r == int'(ra) || (r == int'(rb) && fn != VNOT && fn != VMOV);
    if (op == VSD || op == VBEZ || op == VBNEZ) return r == int'(rd);
    return 1'b0;
  endfunction

  task automatic cyc(input bit r, v, input logic [0:5] op, fn, input logic [0:4] rd, ra, rb, input bit cond);
    @(posedge clk);
    #1;
    reset = r;
    bus.id_valid = v;
    bus.id_opcode = op;
    bus.id_alu_opcode = fn;
    bus.id_rD = rd;
    bus.id_rA = ra;
    bus.id_rB = rb;
    bus.branch_cond = cond;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] x);
    n_cmp++;
    if (got !== x) begin
      n_bad++;
      $display("FAIL %s[%0d]: {stall,flush,issue,busy,done,cnt} got %b_%03b want %b_%03b",
               name, idx, got[7:3], got[2:0], x[7:3], x[2:0]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    int c, free_at, lat, d;
    bit r, v, cond, busy, hz, st, fl, iss;
    logic [0:5] op, fn;
    logic [0:4] rd, ra, rb;
    int k;
    fns = '{VAND, VOR, VXOR, VNOT, VMOV, VADD, VSUB, VMULEU, VMULOU, VSLL, VSRL, VSRA,
            VDIV, VMOD, VSQEU, VSQOU, VSQRT, 6'b111111};
    bus.id_valid = 1'b0; bus.id_opcode = VNOP; bus.id_alu_opcode = '0;
    bus.id_rD = '0; bus.id_rA = '0; bus.id_rB = '0; bus.branch_cond = 1'b0;

    tv.push_back(mk(1, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VADD, 3, 1, 2, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 0, 2)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 1, 1)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VDIV, 4, 1, 2, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, e(1, 0, 0, 1, 0, 4)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, e(1, 0, 0, 1, 0, 3)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, e(1, 0, 0, 1, 0, 2)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, e(1, 0, 0, 1, 1, 1)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, WT ? e(0, 0, 1, 0, 0, 0) : e(1, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VAND, 5, 4, 6, 0, WT ? e(0, 0, 1, 0, 1, 0) : e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VLD, 0, 7, 1, 2, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 1, VBEZ, 0, 7, 0, 0, 1, e(1, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 1, VBEZ, 0, 7, 0, 0, 1, WT ? e(0, 1, 1, 0, 0, 0) : e(1, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VBEZ, 0, 7, 0, 0, 1, WT ? e(0, 1, 1, 0, 1, 0) : e(0, 1, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 1, VALU, VMULEU, 0, 1, 2, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VAND, 10, 1, 2, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 1, VALU, VMOV, 8, 9, 10, 0, e(0, 0, 1, 0, 1, 0)));
    tv.push_back(mk(0, 1, VALU, VOR, 11, 10, 1, 0, WT ? e(0, 0, 1, 0, 1, 0) : e(1, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 0, VNOP, 0, 0, 0, 0, 0, WT ? e(0, 0, 0, 0, 1, 0) : e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VNOP, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0)));
    tv.push_back(mk(0, 1, VBNEZ, 0, 3, 0, 0, 0, e(0, 0, 1, 0, 0, 0)));
    tv.push_back(mk(0, 0, VBEZ, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 1, 0)));
    tv.push_back(mk(0, 1, VSD, 0, 3, 0, 0, 0, e(0, 0, 1, 0, 0, 0)));

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rst, tv[i].v, tv[i].op, tv[i].fn, tv[i].rd, tv[i].ra, tv[i].rb, tv[i].cond);
      if (!tv[i].rst) check("vec", i, tv[i].x);
    end

    cyc(1, 0, VNOP, 0, 0, 0, 0, 0);
    cyc(0, 1, VALU, VSQRT, 12, 1, 2, 0);
    check("sqrt_issue", 0, e(0, 0, 1, 0, 0, 0));
    cyc(0, 0, VNOP, 0, 0, 0, 0, 0);
    check("sqrt_busy4", 0, e(1, 0, 0, 1, 0, 4));
    cyc(1, 0, VNOP, 0, 0, 0, 0, 0);
    check("rst_pre", 0, e(1, 0, 0, 1, 0, 3));
    cyc(0, 0, VNOP, 0, 0, 0, 0, 0);
    check("rst_post", 0, e(0, 0, 0, 0, 0, 0));
    cyc(0, 1, VALU, VOR, 13, 12, 12, 0);
    check("rst_tags_clear", 0, e(0, 0, 1, 0, 0, 0));
    cyc(0, 0, VNOP, 0, 0, 0, 0, 0);
    check("rst_after", 0, e(0, 0, 0, 0, 1, 0));

    cyc(1, 0, VNOP, 0, 0, 0, 0, 0);
    c = 0;
    free_at = 0;
    foreach (ready[j]) ready[j] = 0;
    foreach (done_at[j]) done_at[j] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r = i > 0 && $urandom_range(99) == 0;
      k = int'($urandom_range(9));
      op = k < 5 ? VALU : k == 5 ? VLD : k == 6 ? VSD : k == 7 ? VBEZ : k == 8 ? VBNEZ : VNOP;
      fn = fns[$urandom_range(17)];
      rd = 5'($urandom_range(7));
      ra = 5'($urandom_range(7));
      rb = 5'($urandom_range(7));
      v = $urandom_range(4) != 0;
      cond = 1'($urandom_range(1));
      cyc(r, v, op, fn, rd, ra, rb, cond);
      if (r) begin
        free_at = 0;
        foreach (ready[j]) ready[j] = 0;
        for (int j = c + 1; j < c + 9; j++) done_at[j] = 1'b0;
      end else begin
        busy = c < free_at;
        hz = 1'b0;
        for (int j = 1; j < 32; j++) if (reads(op, fn, rd, ra, rb, j) && ready[j] > c) hz = 1'b1;
        hz = hz && v;
        st = busy || hz;
        iss = !busy && v && !hz && op != VNOP;
        fl = !busy && v && !hz && cond && (op == VBEZ || op == VBNEZ);
        check("rand", i, e(st, fl, iss, busy, done_at[c], busy ? free_at - c : 0));
        if (iss) begin
          lat = lat_of(op, fn, rd);
          free_at = c + lat;
          d = c + (lat > 1 ? lat - 1 : 1);
          done_at[d] = 1'b1;
          if ((op == VALU || op == VLD) && rd != 0) ready[rd] = d + (WT ? 1 : 2);
        end
      end
      c++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
